// File: rtl/ps2_host_if.sv
`timescale 1ns/1ps
`default_nettype none
// ps2_host_if: register-side handshake and status bundle between the
// i8042-style register block (master) and the PS/2 host engine (slave).
interface ps2_host_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       rx_ack;
    logic       err_clr;
    logic [7:0] status;
    logic       irq;

    modport master (
        output tx_data, tx_valid, rx_ack, err_clr,
        input  tx_ready, rx_data, rx_full, status, irq
    );

    modport slave (
        input  tx_data, tx_valid, rx_ack, err_clr,
        output tx_ready, rx_data, rx_full, status, irq
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ps2_host_ctrl: PS/2 host protocol engine; receives device frames into a
// one-byte buffer and sends host commands via inhibit/request-to-send.
module ps2_host_ctrl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    ps2_host_if.slave  bus,
    input  wire logic  ps2_clk_i,
    input  wire logic  ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_RX           = 3'd1,
        S_TX_INHIBIT   = 3'd2,
        S_TX_REQ       = 3'd3,
        S_TX_SHIFT     = 3'd4,
        S_TX_ACK       = 3'd5,
        S_TX_WAIT_IDLE = 3'd6
    } state_t;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [10:0]        rx_shift_q, rx_shift_d;
    logic [8:0]         tx_byte_q, tx_byte_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_full_q, rx_full_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               tx_err_q, tx_err_d;
    logic               timeout_q, timeout_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;

    logic        fe;
    logic        tx_ready_w;
    logic        tx_busy_w;
    logic        timed_w;
    logic [10:0] rx_shift_in_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q  <= 1'b0;
            clk_sync_q  <= 1'b0;
            clk_prev_q  <= 1'b0;
            data_meta_q <= 1'b0;
            data_sync_q <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign fe            = clk_prev_q & ~clk_sync_q;
    assign rx_shift_in_w = {data_sync_q, rx_shift_q[10:1]};
    assign tx_ready_w    = (state_q == S_IDLE) && !fe;
    assign tx_busy_w     = (state_q != S_IDLE) && (state_q != S_RX);
    assign timed_w       = (state_q == S_RX) || (state_q == S_TX_REQ) || (state_q == S_TX_SHIFT)
                        || (state_q == S_TX_ACK) || (state_q == S_TX_WAIT_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_byte_q    <= '0;
            rx_data_q    <= '0;
            rx_full_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            tx_err_q     <= 1'b0;
            timeout_q    <= 1'b0;
            clk_oe_q     <= 1'b0;
            data_oe_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_byte_q    <= tx_byte_d;
            rx_data_q    <= rx_data_d;
            rx_full_q    <= rx_full_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            tx_err_q     <= tx_err_d;
            timeout_q    <= timeout_d;
            clk_oe_q     <= clk_oe_d;
            data_oe_q    <= data_oe_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_byte_d    = tx_byte_q;
        rx_data_d    = rx_data_q;
        rx_full_d    = rx_full_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        tx_err_d     = tx_err_q;
        timeout_d    = timeout_q;
        clk_oe_d     = clk_oe_q;
        data_oe_d    = data_oe_q;

        // Clears are applied first so that any set below wins the same cycle.
        if (bus.rx_ack && rx_full_q)
            rx_full_d = 1'b0;
        if (bus.err_clr) begin
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
            overrun_d    = 1'b0;
            tx_err_d     = 1'b0;
            timeout_d    = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fe) begin
                    state_d    = S_RX;
                    rx_shift_d = rx_shift_in_w;
                    bit_cnt_d  = 4'd1;
                end else if (bus.tx_valid) begin
                    tx_byte_d = {~^bus.tx_data, bus.tx_data};
                    clk_oe_d  = 1'b1;
                    state_d   = S_TX_INHIBIT;
                end
            end
            S_RX: begin
                if (fe) begin
                    rx_shift_d = rx_shift_in_w;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd10) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                        // Shift layout: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
                        if (rx_shift_in_w[0] || !rx_shift_in_w[10]) begin
                            frame_err_d = 1'b1;
                        end else if (!(^rx_shift_in_w[9:1])) begin
                            rx_data_d    = rx_shift_in_w[8:1];
                            rx_full_d    = 1'b1;
                            parity_err_d = 1'b1;
                        end else if (rx_full_q && !bus.rx_ack) begin
                            overrun_d = 1'b1;
                        end else begin
                            rx_data_d = rx_shift_in_w[8:1];
                            rx_full_d = 1'b1;
                        end
                    end
                end
            end
            S_TX_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_TX_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_TX_REQ: begin
                state_d = S_TX_SHIFT;
            end
            S_TX_SHIFT: begin
                if (fe) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q <= 4'd8) begin
                        data_oe_d = ~tx_byte_q[bit_cnt_q];
                    end else if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = S_TX_ACK;
                    end
                end
            end
            S_TX_ACK: begin
                if (fe) begin
                    if (data_sync_q)
                        tx_err_d = 1'b1;
                    state_d = S_TX_WAIT_IDLE;
                end
            end
            S_TX_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Inter-edge watchdog shared by every clocked phase of a frame.
        if (timed_w) begin
            if (fe) begin
                cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
                state_d   = S_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                bit_cnt_d = '0;
                cnt_d     = '0;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.tx_ready = tx_ready_w;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_full  = rx_full_q;
    assign bus.irq      = rx_full_q;
    assign bus.status   = {tx_busy_w, timeout_q, tx_err_q, overrun_q,
                           frame_err_q, parity_err_q, 1'b0, rx_full_q};
    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;

endmodule
`default_nettype wire

// File: doc/ps2_host_ctrl.md
# ps2_host_ctrl

PS/2 host protocol engine that sits beneath the i8042-style Avalon register slave and sequences the physical PS/2 clock/data lines. It deserialises device-to-host frames into a one-byte receive buffer. It serialises host-to-device command bytes using the inhibit/request-to-send procedure. It reports status/error flags and an interrupt level for the register block's status register.

## Interface
- INHIBIT_CYCLES, 5000, clk cycles PS/2 clock is held low before request-to-send (100 us at 50 MHz)
- TIMEOUT_CYCLES, 750000, max clk cycles between PS/2 clock falling edges inside a frame (15 ms at 50 MHz)
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- tx_data  input  8  command byte to send
- tx_valid  input  1  send request; transfer occurs when tx_valid & tx_ready
- tx_ready  output  1  high only in IDLE with no frame in progress
- rx_data  output  8  last received byte
- rx_full  output  1  receive buffer holds an unread byte
- rx_ack  input  1  one-cycle pulse: consume buffer, clears rx_full
- err_clr  input  1  one-cycle pulse: clears all sticky error flags
- status  output  8  {tx_busy, timeout, tx_err, overrun, frame_err, parity_err, 1'b0, rx_full}
- irq  output  1  equals rx_full
- ps2_clk_i  input  1  PS/2 clock pin (asynchronous)
- ps2_data_i  input  1  PS/2 data pin (asynchronous)
- ps2_clk_oe  output  1  1 = drive PS/2 clock low (open drain)
- ps2_data_oe  output  1  1 = drive PS/2 data low (open drain)

## Operation
- Both pins pass through 2-flop synchronisers. A falling edge (fe) is synchronised-prev=1 and synchronised-now=0.
- Frame: start(0), d0..d7 LSB first, odd parity, stop(1); 11 bits.
- States: IDLE, RX, TX_INHIBIT, TX_REQ, TX_SHIFT, TX_ACK, TX_WAIT_IDLE.
- IDLE: fe → RX, sample bit 0. tx_valid&tx_ready with no fe → latch tx_data, compute parity = ~^tx_data, → TX_INHIBIT. If fe and tx_valid coincide, RX wins and tx_ready deasserts that cycle.
- RX: sample data on each fe into an 11-bit shift register. On the 11th sample → IDLE and evaluate the frame:
  - start≠0 or stop≠1: discard, set frame_err.
  - parity wrong: store byte, set rx_full and parity_err.
  - rx_full already set (and no rx_ack same cycle): discard, set overrun.
  - else: rx_data←byte, rx_full←1.
- TX_INHIBIT: clk_oe=1 for INHIBIT_CYCLES → TX_REQ.
- TX_REQ: data_oe=1, clk_oe=0, bit index 0 → TX_SHIFT.
- TX_SHIFT: on each fe drive next bit: data_oe = ~bit for d0..d7, then parity, then stop (data_oe=0). After the fe that follows stop → TX_ACK.
- TX_ACK: on the next fe sample data. 0 = ack, else set tx_err. Then → TX_WAIT_IDLE.
- TX_WAIT_IDLE: wait until both synchronised lines are 1 → IDLE.
- Timeout: in RX, TX_REQ, TX_SHIFT, TX_ACK, TX_WAIT_IDLE a counter resets on every fe. Reaching TIMEOUT_CYCLES → release both oe, set timeout, clear bit index → IDLE. A partial RX frame is discarded.
- Sticky flags (parity_err, frame_err, overrun, tx_err, timeout) clear only on err_clr. Set beats clear in the same cycle.
- rx_ack with rx_full=0 has no effect. rx_ack in the same cycle as a good frame completion: new byte loaded, rx_full stays 1, no overrun.
- tx_busy = state not IDLE and not RX.

## Timing
- Reset values: every output 0 except status = 0 and tx_ready = 1. Internal state IDLE, all counters 0.
- Pin fall to fe: 2–3 clk cycles. Sampling and oe updates register on the cycle after fe.
- rx_full rises 1 cycle after the 11th fe. tx_ready falls the cycle after the handshake.
- TX_INHIBIT lasts exactly INHIBIT_CYCLES clk cycles. clk_oe falls the same edge data_oe rises.
- Reset asserted mid-frame: both oe drop immediately (asynchronous) and the frame is discarded.

## Test plan
- Device sends 0x1C (parity 0, stop 1), 10 kHz PS/2 clock → rx_data=0x1C, rx_full=1, irq=1, errors 0; rx_ack → rx_full=0.
- Device sends 0xAA with bad parity → rx_data=0xAA, rx_full=1, status[2]=1. Then start bit 1 → frame_err, buffer unchanged.
- Two frames 0x12, 0x34 with no rx_ack → rx_data=0x12, overrun=1. err_clr → status=0x01.
- Host sends 0xFF → clk_oe high exactly 5000 cycles; data_oe pattern start, 8×1, parity 1, stop. Device acks with data=0 → tx_err=0, back to IDLE, tx_ready=1.
- Host sends 0xED, device stops clocking after 4 bits → timeout=1 after 750000 cycles, both oe=0, IDLE.
- fe and tx_valid in the same IDLE cycle → RX proceeds, tx_ready=0 until the frame ends. reset_n pulse mid-TX → all outputs at reset values.
